// File: rtl/invntt_gs_butterfly.sv
// Gentleman-Sande butterfly controller for the Kyber inverse NTT: a' = barrett(a+b),
// b' = Montgomery product of zeta and (b-a), computed by an external multiplier.
module invntt_gs_butterfly #(
  parameter int KYBER_Q     = 3329,
  parameter int V           = 20159,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic signed [15:0] i_zeta,
  output logic               busy,
  output logic               valid,
  output logic               err,
  output logic signed [15:0] o_a,
  output logic signed [15:0] o_b,
  output logic               mul_ce,
  output logic signed [15:0] mul_zeta,
  output logic signed [15:0] mul_coeff,
  input  logic signed [15:0] mul_result,
  input  logic               mul_done
);

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);
  localparam logic signed [31:0] V_S     = 32'(V);
  localparam logic signed [31:0] Q_S     = 32'(KYBER_Q);
  localparam logic signed [31:0] ROUND_S = 32'sd33554432;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // Rounded Barrett reduction; the result always fits in 16 bits.
  function automatic logic signed [15:0] barrett_reduce(input logic signed [15:0] x);
    logic signed [31:0] x_w;
    logic signed [31:0] t;
    logic signed [31:0] r;
    x_w = {{16{x[15]}}, x};
    t   = (x_w * V_S + ROUND_S) >>> 26;
    r   = x_w - t * Q_S;
    return r[15:0];
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [15:0] sum_q;
  logic signed [15:0] red_q;
  logic signed [15:0] o_a_q, o_b_q;
  logic signed [15:0] mul_zeta_q, mul_coeff_q;
  logic               busy_q, valid_q, err_q, mul_ce_q;

  logic signed [15:0] sum_d, diff_d;
  assign sum_d  = i_a + i_b;
  assign diff_d = i_b - i_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      red_q       <= '0;
      o_a_q       <= '0;
      o_b_q       <= '0;
      mul_zeta_q  <= '0;
      mul_coeff_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mul_ce_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      mul_ce_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q       <= sum_d;
            mul_coeff_q <= diff_d;
            mul_zeta_q  <= i_zeta;
            mul_ce_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          red_q   <= barrett_reduce(sum_q);
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The valid/err pulse cycle is still spent here so start is not yet accepted.
          if (valid_q || err_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (mul_done) begin
            o_a_q   <= red_q;
            o_b_q   <= mul_result;
            valid_q <= 1'b1;
          end else if (cnt_q == CNT_W'(MUL_TIMEOUT - 1)) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign o_a       = o_a_q;
  assign o_b       = o_b_q;
  assign mul_ce    = mul_ce_q;
  assign mul_zeta  = mul_zeta_q;
  assign mul_coeff = mul_coeff_q;

endmodule

// File: tb/tb_invntt_gs_butterfly.sv
// Bench for invntt_gs_butterfly: stub multiplier with programmable latency, a
// transaction-level timeline model checked every cycle, and directed literal checks.
module tb_invntt_gs_butterfly;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] i_a = '0, i_b = '0, i_zeta = '0;
  logic               busy, valid, err, mul_ce;
  logic signed [15:0] o_a, o_b, mul_zeta, mul_coeff;
  logic signed [15:0] mul_result;
  logic               mul_done;

  int          stub_lat = 6;
  logic [15:0] stub_res = '0;
  logic        stub_done;
  int          stub_cnt;
  logic        inj_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  invntt_gs_butterfly dut (
    .clk(clk), .rst(rst), .start(start), .i_a(i_a), .i_b(i_b), .i_zeta(i_zeta),
    .busy(busy), .valid(valid), .err(err), .o_a(o_a), .o_b(o_b),
    .mul_ce(mul_ce), .mul_zeta(mul_zeta), .mul_coeff(mul_coeff),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  // Stub multiplier: done pulse L cycles after the strobe; L >= 16 means never.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      stub_done <= 1'b0;
      if (mul_ce && stub_lat < 16) begin
        if (stub_lat <= 1) stub_done <= 1'b1;
        else stub_cnt <= stub_lat - 1;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) stub_done <= 1'b1;
      end
    end
  end
  assign mul_done   = stub_done | inj_done;
  assign mul_result = stub_res;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int w16(input int x);
    int m;
    m = ((x % 65536) + 65536) % 65536;
    return (m >= 32768) ? m - 65536 : m;
  endfunction

  // Rounded Barrett with explicit floor division.
  function automatic int mb(input int s);
    longint num, q;
    num = 64'(20159) * s + 64'(33554432);
    q = num / 67108864;
    if (num < 0 && q * 67108864 != num) q = q - 1;
    return int'(s - q * 3329);
  endfunction

  // Timeline model: an accepted start at cycle t0 gives the strobe at t0+1 and
  // finishes at t0+2+L (valid) or t0+17 (err).
  int cyc = 0, t0 = -100, tend = -100;
  bit ok_p = 1'b0;
  int pa = 0, pres = 0;
  int e_oa = 0, e_ob = 0, e_coef = 0, e_zeta = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      t0 = -100; tend = -100;
      e_oa = 0; e_ob = 0; e_coef = 0; e_zeta = 0;
    end else if (cyc == tend && ok_p) begin
      e_oa = pa; e_ob = pres;
    end
    chk("busy",      busy,   int'(!rst && cyc > t0 && cyc <= tend));
    chk("mul_ce",    mul_ce, int'(!rst && cyc == t0 + 1));
    chk("valid",     valid,  int'(!rst && cyc == tend && ok_p));
    chk("err",       err,    int'(!rst && cyc == tend && !ok_p));
    chk("o_a",       o_a,       e_oa);
    chk("o_b",       o_b,       e_ob);
    chk("mul_coeff", mul_coeff, e_coef);
    chk("mul_zeta",  mul_zeta,  e_zeta);
    if (!rst && start && cyc > tend) begin
      t0     = cyc;
      ok_p   = (stub_lat <= 15);
      tend   = ok_p ? cyc + 2 + stub_lat : cyc + 17;
      pa     = mb(w16(int'(i_a) + int'(i_b)));
      pres   = int'($signed(stub_res));
      e_coef = w16(int'(i_b) - int'(i_a));
      e_zeta = int'(i_zeta);
    end
  end

  task automatic op(input int a, input int b, input int z, input int lat, input int res,
                    input bit inj, output bit gv, output bit ge, output int dcyc,
                    output int coef_s, output bit ce_s);
    bit found;
    found = 1'b0;
    i_a = 16'(a); i_b = 16'(b); i_zeta = 16'(z);
    stub_lat = lat; stub_res = 16'(res);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    coef_s = int'(mul_coeff);
    ce_s = mul_ce;
    if (inj) inj_done = 1'b1;
    gv = 1'b0; ge = 1'b0; dcyc = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(posedge clk); #1;
      inj_done = 1'b0;
      if (valid || err) begin
        found = 1'b1; gv = valid; ge = err; dcyc = k + 1;
      end
    end
    if (!found) chk("op_done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit gv, ge, ce_s;
    int dcyc, coef_s, nce, nv;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_o_a", o_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic latency and handshake
    op(100, 200, 17, 6, 16'h1234, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t1_valid", gv, 1);
    chk("t1_cycle", dcyc, 8);
    chk("t1_o_a", o_a, 300);
    chk("t1_o_b", o_b, 16'h1234);
    chk("t1_coeff", coef_s, 100);
    chk("t1_ce", ce_s, 1);
    chk("t1_zeta", mul_zeta, 17);

    // 2: reduction corners
    op(3000, 3000, 5, 4, 77, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t2a_o_a", o_a, -658);
    chk("t2a_coeff", coef_s, 0);
    op(-3329, -3329, 5, 2, -9, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t2b_o_a", o_a, 0);
    chk("t2b_coeff", coef_s, 0);
    chk("t2b_o_b", o_b, -9);

    // 3: int16 wrap
    op(20000, 20000, 1, 3, 5, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t3a_o_a", o_a, 1096);
    op(-20000, 20000, 1, 3, 6, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t3b_coeff", coef_s, -25536);

    // 4: timeout, then normal recovery
    op(11, 22, 33, 16, 44, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t4_valid", gv, 0);
    chk("t4_err", ge, 1);
    chk("t4_cycle", dcyc, 17);
    chk("t4_busy", busy, 0);
    chk("t4_o_b_hold", o_b, 6);
    op(1, 2, 3, 5, 123, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t4_recover", gv, 1);
    chk("t4_recover_o_b", o_b, 123);

    // 5: stale done in ISSUE, done coinciding with timeout, held start
    op(7, 9, 4, 5, 321, 1'b1, gv, ge, dcyc, coef_s, ce_s);
    chk("t5_stale_cycle", dcyc, 7);
    op(7, 9, 4, 15, 322, 1'b0, gv, ge, dcyc, coef_s, ce_s);
    chk("t5_tie_valid", gv, 1);
    chk("t5_tie_err", ge, 0);
    chk("t5_tie_cycle", dcyc, 17);
    nce = 0; nv = 0;
    i_a = 16'(50); i_b = 16'(-60); i_zeta = 16'(99); stub_lat = 3; stub_res = 16'(555);
    start = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      nce += int'(mul_ce); nv += int'(valid);
    end
    start = 1'b0;
    for (int k = 0; k < 30 && busy; k++) begin
      @(posedge clk); #1;
      nce += int'(mul_ce); nv += int'(valid);
    end
    chk("t5_held_ce_eq_valid", nce, nv);
    chk("t5_held_multi", int'(nce >= 3), 1);
    @(posedge clk); #1;

    // 6: reset during WAIT, late done afterwards
    i_a = 16'(10); i_b = 16'(20); i_zeta = 16'(30); stub_lat = 10; stub_res = 16'(999);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mul_ce", mul_ce, 0);
    chk("t6_o_a", o_a, 0);
    chk("t6_o_b", o_b, 0);
    chk("t6_coeff", mul_coeff, 0);
    chk("t6_zeta", mul_zeta, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    nv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      nv += int'(valid);
    end
    chk("t6_no_valid", nv, 0);

    // Randomized traffic, checked by the timeline model every cycle
    for (int n = 0; n < 40; n++) begin
      op(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
         int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(1, 17)),
         int'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0),
         gv, ge, dcyc, coef_s, ce_s);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
